lsu_mem_ctrl: RTL and testbench

Load/store controller sitting directly upstream of the data Memory block in the NPC core. Accepts one load or store request at a time from the execute stage and converts it into a word-aligned Memory access: pulsed read/write strobes, byte lane shifting and a 4-bit write mask. For loads it extracts the addressed byte or halfword from the returned word and sign- or zero-extends it. Returns a single response per request, with an error flag for misaligned or illegal-size accesses.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_mem_ctrl_lane.sv | 55 +++++
 rtl/lsu_mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   - request size encodings
//   - controller state enum
//   - alignment check helper
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_WR,
      ST_RESP
   } lsu_state_t;

   // Misaligned when a halfword sits on an odd byte or a word is not on a
   // 4-byte boundary. Byte accesses are always aligned.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      if (size == SZ_H && off[0])
         mis = 1'b1;
      else if (size == SZ_W && off != 2'b00)
         mis = 1'b1;
      return mis;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane.sv
// Byte-lane steering for the load/store controller (combinational).
//   i_size      access size (SZ_B/SZ_H/SZ_W)
//   i_unsigned  1 = zero-extend loads, 0 = sign-extend
//   i_off       byte offset within the word
//   i_wdata     right-aligned store data
//   i_rdata     word read from memory
//   o_st_wdata  store data replicated onto every lane
//   o_st_wmask  byte enables for the store
//   o_ld_data   extracted and extended load data
module lsu_mem_ctrl_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_st_wdata,
   output logic [3:0]  o_st_wmask,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_st_wdata = '0;
      o_st_wmask = '0;
      o_ld_data  = '0;
      w_shifted  = i_rdata >> {i_off, 3'b000};
      w_byte     = w_shifted[7:0];
      w_half     = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_size)
         SZ_B: begin
            // Replicating the byte puts it on every lane; the mask picks one.
            o_st_wdata = {4{i_wdata[7:0]}};
            o_st_wmask = 4'b0001 << i_off;
            o_ld_data  = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_H: begin
            o_st_wdata = {2{i_wdata[15:0]}};
            o_st_wmask = 4'b0011 << i_off;
            o_ld_data  = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         SZ_W: begin
            o_st_wdata = i_wdata;
            o_st_wmask = 4'b1111;
            o_ld_data  = i_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the data memory. Takes one request at a
// time, issues a single word-aligned read or write strobe, and returns one
// response (extended load data or error flag).
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_*, o_req_ready  request from execute stage
//   o_resp_*, i_resp_ready response back to execute stage
//   o_mem_*, i_mem_rdata  memory port (pulsed strobes, word addresses)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a request
// ST_RD_WAIT | read strobe issued, counting to the read-data capture edge
// ST_WR      | write strobe high for this single cycle
// ST_RESP    | first cycle builds the response, then hold until accepted
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int READ_LATENCY = 1   // 1..7
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wen,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_mem_ren,
   output logic [31:0] o_mem_raddr,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_waddr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wmask,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [2:0] LP_CNT_LAST = 3'(READ_LATENCY - 1);

   lsu_state_t  r_state;
   logic [2:0]  r_cnt;
   logic [1:0]  r_size;
   logic [1:0]  r_off;
   logic        r_unsigned;
   logic        r_wen;
   logic        r_err;
   logic [31:0] r_rdata_cap;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;
   logic        r_mem_ren;
   logic        r_mem_wen;
   logic [31:0] r_mem_raddr;
   logic [31:0] r_mem_waddr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wmask;

   logic        w_idle;
   logic        w_err;
   logic [1:0]  w_lane_size;
   logic [1:0]  w_lane_off;
   logic [31:0] w_st_wdata;
   logic [3:0]  w_st_wmask;
   logic [31:0] w_ld_data;

   assign w_idle = (r_state == ST_IDLE);
   assign w_err  = (i_req_size == 2'b11) || lsu_misaligned(i_req_size, i_req_addr[1:0]);

   // One lane unit serves both directions: in IDLE it shapes the incoming
   // store, afterwards it extracts from the captured read word.
   assign w_lane_size = w_idle ? i_req_size : r_size;
   assign w_lane_off  = w_idle ? i_req_addr[1:0] : r_off;

   lsu_mem_ctrl_lane u_lane (
      .i_size     (w_lane_size),
      .i_unsigned (r_unsigned),
      .i_off      (w_lane_off),
      .i_wdata    (i_req_wdata),
      .i_rdata    (r_rdata_cap),
      .o_st_wdata (w_st_wdata),
      .o_st_wmask (w_st_wmask),
      .o_ld_data  (w_ld_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_size       <= '0;
         r_off        <= '0;
         r_unsigned   <= 1'b0;
         r_wen        <= 1'b0;
         r_err        <= 1'b0;
         r_rdata_cap  <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_mem_ren    <= 1'b0;
         r_mem_wen    <= 1'b0;
         r_mem_raddr  <= '0;
         r_mem_waddr  <= '0;
         r_mem_wdata  <= '0;
         r_mem_wmask  <= '0;
      end else begin
         r_mem_ren <= 1'b0;
         r_mem_wen <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_size      <= i_req_size;
                  r_off       <= i_req_addr[1:0];
                  r_unsigned  <= i_req_unsigned;
                  r_wen       <= i_req_wen;
                  r_err       <= w_err;
                  r_cnt       <= '0;
                  if (w_err) begin
                     r_state <= ST_RESP;
                  end else if (i_req_wen) begin
                     r_state     <= ST_WR;
                     r_mem_wen   <= 1'b1;
                     r_mem_waddr <= {i_req_addr[31:2], 2'b00};
                     r_mem_wdata <= w_st_wdata;
                     r_mem_wmask <= w_st_wmask;
                  end else begin
                     r_state     <= ST_RD_WAIT;
                     r_mem_ren   <= 1'b1;
                     r_mem_raddr <= {i_req_addr[31:2], 2'b00};
                  end
               end
            end
            ST_RD_WAIT: begin
               if (r_cnt == LP_CNT_LAST) begin
                  r_rdata_cap <= i_mem_rdata;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_WR: begin
               r_state <= ST_RESP;
            end
            ST_RESP: begin
               if (!r_resp_valid) begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= r_err;
                  r_resp_rdata <= (r_err || r_wen) ? 32'h0 : w_ld_data;
               end else if (i_resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= '0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;
   assign o_mem_ren    = r_mem_ren;
   assign o_mem_raddr  = r_mem_raddr;
   assign o_mem_wen    = r_mem_wen;
   assign o_mem_waddr  = r_mem_waddr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_mem_wmask  = r_mem_wmask;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: one instance at the default read latency
// and one at latency 3, sharing clock and reset.
module tb_lsu_mem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // instance A: READ_LATENCY = 1
   logic        req_valid = 0, req_wen = 0, req_unsigned = 0, resp_ready = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
   logic        req_ready, resp_valid, resp_err, mem_ren, mem_wen;
   logic [31:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata;
   logic [3:0]  mem_wmask;

   // instance B: READ_LATENCY = 3
   logic        b_req_valid = 0, b_req_wen = 0, b_req_unsigned = 0, b_resp_ready = 0;
   logic [1:0]  b_req_size = 0;
   logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_mem_rdata = 0;
   logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_ren, b_mem_wen;
   logic [31:0] b_resp_rdata, b_mem_raddr, b_mem_waddr, b_mem_wdata;
   logic [3:0]  b_mem_wmask;

   lsu_mem_ctrl #(.READ_LATENCY(1)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
      .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .o_mem_ren(mem_ren),
      .o_mem_raddr(mem_raddr), .o_mem_wen(mem_wen), .o_mem_waddr(mem_waddr),
      .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask), .i_mem_rdata(mem_rdata)
   );

   lsu_mem_ctrl #(.READ_LATENCY(3)) u_dut3 (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_wen(b_req_wen),
      .i_req_size(b_req_size), .i_req_unsigned(b_req_unsigned), .i_req_addr(b_req_addr),
      .i_req_wdata(b_req_wdata), .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
      .o_resp_rdata(b_resp_rdata), .o_resp_err(b_resp_err), .o_mem_ren(b_mem_ren),
      .o_mem_raddr(b_mem_raddr), .o_mem_wen(b_mem_wen), .o_mem_waddr(b_mem_waddr),
      .o_mem_wdata(b_mem_wdata), .o_mem_wmask(b_mem_wmask), .i_mem_rdata(b_mem_rdata)
   );

   // strobe-cycle counters
   int n_ren = 0, n_wen = 0, n_ren3 = 0, n_rv = 0;
   always @(posedge clk) begin
      if (mem_ren)    n_ren++;
      if (mem_wen)    n_wen++;
      if (b_mem_ren)  n_ren3++;
      if (resp_valid) n_rv++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1; req_wen = wen; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
   endtask

   task automatic handshake();
      resp_ready = 1;
      tick();
      resp_ready = 0;
      chk("hs_resp_valid", resp_valid, 0);
      chk("hs_req_ready", req_ready, 1);
   endtask

   logic [31:0] held;
   int          ren0, wen0, rv0;

   initial begin
      tick(); tick();
      rst = 0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_ren", mem_ren, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_raddr", mem_raddr, 0);
      chk("rst_waddr", mem_waddr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wmask", mem_wmask, 0);

      // SB 0x80000003 <- 0xAB
      req(1, 2'b00, 0, 32'h8000_0003, 32'h0000_00AB);
      wen0 = n_wen;
      tick();
      req_valid = 0;
      chk("sb_wen", mem_wen, 1);
      chk("sb_waddr", mem_waddr, 32'h8000_0000);
      chk("sb_wmask", mem_wmask, 4'b1000);
      chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      chk("sb_ren", mem_ren, 0);
      chk("sb_rv_e0", resp_valid, 0);
      tick();
      chk("sb_wen_e1", mem_wen, 0);
      chk("sb_rv_e1", resp_valid, 0);
      tick();
      chk("sb_rv_e2", resp_valid, 1);
      chk("sb_err", resp_err, 0);
      chk("sb_rdata", resp_rdata, 0);
      chk("sb_wen_pulses", n_wen - wen0, 1);
      handshake();

      // LH signed / LHU at 0x80000002, memory word 0x80011234
      mem_rdata = 32'h8001_1234;
      for (int u = 0; u < 2; u++) begin
         req(0, 2'b01, u[0], 32'h8000_0002, 32'h0);
         tick();
         req_valid = 0;
         chk("lh_ren", mem_ren, 1);
         chk("lh_raddr", mem_raddr, 32'h8000_0000);
         tick();
         chk("lh_ren_e1", mem_ren, 0);
         chk("lh_rv_e1", resp_valid, 0);
         tick();
         chk("lh_rv_e2", resp_valid, 1);
         chk("lh_rdata", resp_rdata, (u == 0) ? 32'hFFFF_8001 : 32'h0000_8001);
         chk("lh_err", resp_err, 0);
         handshake();
      end

      // misaligned LW and illegal size: error after one cycle, no strobe
      ren0 = n_ren;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) req(0, 2'b10, 0, 32'h8000_0001, 32'h0);
         else        req(0, 2'b11, 0, 32'h8000_0000, 32'h0);
         tick();
         req_valid = 0;
         chk("err_ren", mem_ren, 0);
         chk("err_rv_e0", resp_valid, 0);
         tick();
         chk("err_rv_e1", resp_valid, 1);
         chk("err_flag", resp_err, 1);
         chk("err_rdata", resp_rdata, 0);
         handshake();
      end
      chk("err_no_ren", n_ren - ren0, 0);

      // backpressure on an aligned LW; a competing store must wait
      mem_rdata = 32'hCAFE_F00D;
      req(0, 2'b10, 0, 32'h8000_0004, 32'h0);
      tick();
      req(1, 2'b01, 0, 32'h8000_0006, 32'h0000_BEEF);
      tick();
      mem_rdata = 32'h1111_1111;
      tick();
      chk("bp_rv", resp_valid, 1);
      chk("bp_rdata0", resp_rdata, 32'hCAFE_F00D);
      held = resp_rdata;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_rv_hold", resp_valid, 1);
         chk("bp_rdata_hold", resp_rdata, 32'hCAFE_F00D);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_no_wen", mem_wen, 0);
      end
      resp_ready = 1;
      tick();
      resp_ready = 0;
      chk("bp_hs_rv", resp_valid, 0);
      chk("bp_hs_no_accept", mem_wen, 0);
      chk("bp_hs_ready", req_ready, 1);
      tick();
      req_valid = 0;
      chk("sh_wen", mem_wen, 1);
      chk("sh_wmask", mem_wmask, 4'b1100);
      chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("sh_waddr", mem_waddr, 32'h8000_0004);
      tick(); tick();
      chk("sh_rv", resp_valid, 1);
      handshake();

      // reset while in RD_WAIT
      req(0, 2'b10, 0, 32'h8000_0008, 32'h0);
      tick();
      req_valid = 0;
      chk("rr_ren", mem_ren, 1);
      rst = 1;
      rv0 = n_rv;
      tick();
      rst = 0;
      chk("rr_req_ready", req_ready, 1);
      chk("rr_ren_drop", mem_ren, 0);
      chk("rr_raddr", mem_raddr, 0);
      chk("rr_waddr", mem_waddr, 0);
      chk("rr_wmask", mem_wmask, 0);
      chk("rr_rv", resp_valid, 0);
      tick(); tick(); tick();
      chk("rr_no_resp", n_rv - rv0, 0);
      req(1, 2'b10, 0, 32'h8000_0010, 32'h1234_5678);
      tick();
      req_valid = 0;
      chk("sw_wen", mem_wen, 1);
      chk("sw_wmask", mem_wmask, 4'b1111);
      chk("sw_wdata", mem_wdata, 32'h1234_5678);
      chk("sw_waddr", mem_waddr, 32'h8000_0010);
      tick(); tick();
      chk("sw_rv", resp_valid, 1);
      chk("sw_err", resp_err, 0);
      handshake();

      // latency 3: LBU at offset 1 and LB at offset 3; data valid only at capture edge
      for (int j = 0; j < 2; j++) begin
         ren0 = n_ren3;
         b_mem_rdata = 32'hDEAD_BEEF;
         b_req_valid = 1; b_req_wen = 0; b_req_size = 2'b00;
         b_req_unsigned = (j == 0);
         b_req_addr = (j == 0) ? 32'h1000_0001 : 32'h1000_0003;
         tick();
         b_req_valid = 0;
         chk("l3_ren", b_mem_ren, 1);
         chk("l3_raddr", b_mem_raddr, 32'h1000_0000);
         tick();
         chk("l3_ren_e1", b_mem_ren, 0);
         tick();
         b_mem_rdata = (j == 0) ? 32'h0000_7F00 : 32'h8500_0000;
         tick();
         b_mem_rdata = 32'hFFFF_FFFF;
         chk("l3_rv_e3", b_resp_valid, 0);
         tick();
         chk("l3_rv_e4", b_resp_valid, 1);
         chk("l3_rdata", b_resp_rdata, (j == 0) ? 32'h0000_007F : 32'hFFFF_FF85);
         chk("l3_ren_pulses", n_ren3 - ren0, 1);
         b_resp_ready = 1;
         tick();
         b_resp_ready = 0;
         chk("l3_hs_rv", b_resp_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
